// File: rtl/axi_lite_pkg.sv
// Shared types for the AXI-Lite master: bus response codes, the master's
// FSM state encoding, and the helper that gives the number of byte-offset
// address bits for a data width.
package axi_lite_pkg;

   // Response codes carried on BRESP/RRESP and returned on rsp_resp.
   typedef enum logic [1:0] {
      OKAY   = 2'b00,
      EXOKAY = 2'b01,
      SLVERR = 2'b10,
      DECERR = 2'b11
   } axi_resp_e;

   // One transaction in flight at a time: write path, read path, then RSP.
   typedef enum logic [2:0] {
      IDLE,
      WR,
      WR_B,
      RD_A,
      RD_R,
      RSP
   } state_e;

   // Number of low address bits that select a byte within one data beat.
   function automatic int addr_lsb(input int data_width);
      return $clog2(data_width / 8);
   endfunction

endpackage

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI-Lite master. A command (read or write) is taken
// from the cmd_* port in IDLE, issued on the AXI-Lite channels, and the
// slave's response is presented on rsp_* until consumed.
//
// Optional build macro AXI_LITE_MASTER_ALIGN_CHECK_EN: when defined, a
// command with nonzero byte-offset address bits is answered locally with
// SLVERR and no bus traffic; when undefined the offset bits are cleared and
// the transaction is issued normally.
module axi_lite_master
   import axi_lite_pkg::*;
#(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32
) (
   input  logic                    aclk,
   input  logic                    areset,

   // command side
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic                    cmd_write,
   input  logic [ADDR_WIDTH-1:0]   cmd_addr,
   input  logic [DATA_WIDTH-1:0]   cmd_wdata,
   input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,

   // completion side
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [DATA_WIDTH-1:0]   rsp_rdata,
   output logic [1:0]              rsp_resp,

   // write-address channel
   output logic [ADDR_WIDTH-1:0]   M_AXI_LITE_awaddr,
   output logic                    M_AXI_LITE_awvalid,
   input  logic                    M_AXI_LITE_awready,

   // write-data channel
   output logic [DATA_WIDTH-1:0]   M_AXI_LITE_wdata,
   output logic [DATA_WIDTH/8-1:0] M_AXI_LITE_wstrb,
   output logic                    M_AXI_LITE_wvalid,
   input  logic                    M_AXI_LITE_wready,

   // write-response channel
   input  logic [1:0]              M_AXI_LITE_bresp,
   input  logic                    M_AXI_LITE_bvalid,
   output logic                    M_AXI_LITE_bready,

   // read-address channel
   output logic [ADDR_WIDTH-1:0]   M_AXI_LITE_araddr,
   output logic                    M_AXI_LITE_arvalid,
   input  logic                    M_AXI_LITE_arready,

   // read-data channel
   input  logic [DATA_WIDTH-1:0]   M_AXI_LITE_rdata,
   input  logic [1:0]              M_AXI_LITE_rresp,
   input  logic                    M_AXI_LITE_rvalid,
   output logic                    M_AXI_LITE_rready
);

   localparam int ADDR_LSB = addr_lsb(DATA_WIDTH);
   // Keeps the beat-address bits, clears the byte-offset bits.
   localparam logic [ADDR_WIDTH-1:0] ADDR_KEEP = {ADDR_WIDTH{1'b1}} << ADDR_LSB;

   // Reject unsupported configurations at elaboration.
   if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_data_width
      $error("axi_lite_master: DATA_WIDTH must be 32 or 64");
   end
   if (ADDR_WIDTH < 1 || ADDR_WIDTH > 64) begin : g_bad_addr_width
      $error("axi_lite_master: ADDR_WIDTH must be 1..64");
   end

   state_e                  state_q;
   state_e                  state_d;

   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [DATA_WIDTH-1:0]   wdata_q;
   logic [DATA_WIDTH/8-1:0] wstrb_q;
   logic                    write_q;
   logic                    awvalid_q;
   logic                    wvalid_q;
   logic                    arvalid_q;
   logic [DATA_WIDTH-1:0]   rdata_q;
   axi_resp_e               resp_q;

   logic                    cmd_accept;
   logic                    cmd_reject;
   logic                    aw_hs;
   logic                    w_hs;
   logic                    ar_hs;
   logic                    b_hs;
   logic                    r_hs;
   logic                    aw_done;
   logic                    w_done;
   logic                    bus_rsp;

   // Commands are only taken in IDLE and never while reset is asserted.
   assign cmd_ready  = (state_q == IDLE) && !areset;
   assign cmd_accept = cmd_valid && cmd_ready;

`ifdef AXI_LITE_MASTER_ALIGN_CHECK_EN
   assign cmd_reject = |(cmd_addr & ~ADDR_KEEP);
`else
   assign cmd_reject = 1'b0;
`endif

   // Channel handshakes; every valid/ready the master drives is registered
   // or decoded from the registered state, so none depends on a ready input.
   assign aw_hs   = awvalid_q && M_AXI_LITE_awready;
   assign w_hs    = wvalid_q && M_AXI_LITE_wready;
   assign ar_hs   = arvalid_q && M_AXI_LITE_arready;
   assign b_hs    = M_AXI_LITE_bvalid && M_AXI_LITE_bready;
   assign r_hs    = M_AXI_LITE_rvalid && M_AXI_LITE_rready;

   // AW and W complete independently; a channel is done once its valid has
   // dropped or its handshake happens this cycle.
   assign aw_done = !awvalid_q || aw_hs;
   assign w_done  = !wvalid_q || w_hs;
   assign bus_rsp = b_hs || r_hs;

   // State register.
   always_ff @(posedge aclk) begin
      // NOTE: sequential state is updated with non-blocking assignments so
      // every register samples the pre-edge values of the others.
      if (areset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state decode.
   always_comb begin
      // NOTE: assigning the default first means every path drives state_d,
      // so no latch is inferred.
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (cmd_accept) begin
               if (cmd_reject) begin
                  state_d = RSP;
               end else if (cmd_write) begin
                  state_d = WR;
               end else begin
                  state_d = RD_A;
               end
            end
         end
         WR: begin
            if (aw_done && w_done) begin
               state_d = WR_B;
            end
         end
         WR_B: begin
            if (b_hs) begin
               state_d = RSP;
            end
         end
         RD_A: begin
            if (ar_hs) begin
               state_d = RD_R;
            end
         end
         RD_R: begin
            if (r_hs) begin
               state_d = RSP;
            end
         end
         RSP: begin
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Command capture, per-channel valid flags and response capture.
   always_ff @(posedge aclk) begin
      // NOTE: the synchronous reset clears payload registers as well as
      // control so the bus shows all-zero addresses and data after reset.
      if (areset) begin
         addr_q    <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         write_q   <= 1'b0;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         arvalid_q <= 1'b0;
         rdata_q   <= '0;
         resp_q    <= OKAY;
      end else begin
         if (cmd_accept) begin
            addr_q    <= cmd_addr & ADDR_KEEP;
            wdata_q   <= cmd_wdata;
            wstrb_q   <= cmd_wstrb;
            write_q   <= cmd_write;
            awvalid_q <= cmd_write && !cmd_reject;
            wvalid_q  <= cmd_write && !cmd_reject;
            arvalid_q <= !cmd_write && !cmd_reject;
            if (cmd_reject) begin
               rdata_q <= '0;
               resp_q  <= SLVERR;
            end
         end else begin
            if (aw_hs) begin
               awvalid_q <= 1'b0;
            end
            if (w_hs) begin
               wvalid_q <= 1'b0;
            end
            if (ar_hs) begin
               arvalid_q <= 1'b0;
            end
         end

         // Only one of B or R can complete, and only in its own state.
         if (bus_rsp) begin
            rdata_q <= write_q ? '0 : M_AXI_LITE_rdata;
            resp_q  <= axi_resp_e'(write_q ? M_AXI_LITE_bresp : M_AXI_LITE_rresp);
         end
      end
   end

   assign M_AXI_LITE_awaddr  = addr_q;
   assign M_AXI_LITE_awvalid = awvalid_q;
   assign M_AXI_LITE_wdata   = wdata_q;
   assign M_AXI_LITE_wstrb   = wstrb_q;
   assign M_AXI_LITE_wvalid  = wvalid_q;
   assign M_AXI_LITE_bready  = (state_q == WR_B);
   assign M_AXI_LITE_araddr  = addr_q;
   assign M_AXI_LITE_arvalid = arvalid_q;
   assign M_AXI_LITE_rready  = (state_q == RD_R);

   assign rsp_valid = (state_q == RSP);
   assign rsp_rdata = rdata_q;
   assign rsp_resp  = resp_q;

endmodule

// File: doc/axi_lite_master.md
AXI_LITE_MASTER -- requirements
Module: axi_lite_master

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, AXI-Lite address width (max 64).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, AXI-Lite data width (32 or 64 only; elaboration error otherwise).
REQ-003 SHALL have port aclk  input  1  clock; one clock, all logic on its rising edge.
REQ-004 SHALL have port areset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port cmd_valid  input  1  command request.
REQ-006 SHALL have port cmd_ready  output  1  command accepted when high with cmd_valid.
REQ-007 SHALL have port cmd_write  input  1  1=write, 0=read.
REQ-008 SHALL have port cmd_addr  input  ADDR_WIDTH  byte address.
REQ-009 SHALL have port cmd_wdata  input  DATA_WIDTH  write data.
REQ-010 SHALL have port cmd_wstrb  input  DATA_WIDTH/8  write byte strobes.
REQ-011 SHALL have port rsp_valid  output  1  completion available.
REQ-012 SHALL have port rsp_ready  input  1  completion consumed.
REQ-013 SHALL have port rsp_rdata  output  DATA_WIDTH  read data (0 for writes).
REQ-014 SHALL have port rsp_resp  output  2  captured BRESP/RRESP.
REQ-015 SHALL have ports M_AXI_LITE_awaddr  output  ADDR_WIDTH, M_AXI_LITE_awvalid  output  1, M_AXI_LITE_awready  input  1: write-address channel.
REQ-016 SHALL have ports M_AXI_LITE_wdata  output  DATA_WIDTH, M_AXI_LITE_wstrb  output  DATA_WIDTH/8, M_AXI_LITE_wvalid  output  1, M_AXI_LITE_wready  input  1: write-data channel.
REQ-017 SHALL have ports M_AXI_LITE_bresp  input  2, M_AXI_LITE_bvalid  input  1, M_AXI_LITE_bready  output  1: write-response channel.
REQ-018 SHALL have ports M_AXI_LITE_araddr  output  ADDR_WIDTH, M_AXI_LITE_arvalid  output  1, M_AXI_LITE_arready  input  1: read-address channel.
REQ-019 SHALL have ports M_AXI_LITE_rdata  input  DATA_WIDTH, M_AXI_LITE_rresp  input  2, M_AXI_LITE_rvalid  input  1, M_AXI_LITE_rready  output  1: read-data channel.

Function
REQ-020 SHALL implement FSM states IDLE, WR, WR_B, RD_A, RD_R, RSP; at most one transaction outstanding.
REQ-021 SHALL drive cmd_ready=1 only in IDLE; on cmd_valid&cmd_ready, register addr (low log2(DATA_WIDTH/8) bits zeroed), wdata, wstrb, write; go to WR if cmd_write, else RD_A.
REQ-022 WR SHALL assert awvalid and wvalid together from the cycle after acceptance; each drops the cycle after its own handshake, independently, in either order or simultaneously; go to WR_B when both are done.
REQ-023 SHALL keep every valid and its payload registered and stable until handshake, never dependent combinationally on ready.
REQ-024 WR_B SHALL assert bready; on bvalid&bready capture bresp, set rsp_rdata=0, go to RSP.
REQ-025 RD_A SHALL assert arvalid until arready; RD_R SHALL assert rready; on rvalid&rready capture rdata/rresp, go to RSP.
REQ-026 RSP SHALL hold rsp_valid=1 with stable rsp_rdata/rsp_resp until rsp_ready; then go to IDLE; new command accepted no earlier than the following cycle.
REQ-027 SHALL tolerate arbitrary slave wait states on every channel with no timeout; bresp/rresp passed through unmodified.

Reset
REQ-028 On areset=1 SHALL enter IDLE next edge; all valids, bready, rready, rsp_valid = 0; cmd_ready = 0 during reset; address/data/resp registers = 0; any in-flight transaction is abandoned.

Configuration
REQ-029 With AXI_LITE_MASTER_ALIGN_CHECK_EN defined, a command whose low address bits are nonzero SHALL issue no bus traffic and go directly to RSP with rsp_resp=2'b10, rsp_rdata=0; without it, low bits are zeroed per REQ-021 and the transaction is issued.

Structure
REQ-030 Package axi_lite_pkg SHALL hold the response enum (OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3), the FSM state enum, and the ADDR_LSB helper; single module, no sub-module.

Verification
REQ-031 Against the team register slave: write 0x00=5, 0x04=3, read 0x08 -> rsp_rdata=8, 0x0C -> 2, 0x10 -> 15, all rsp_resp=0.
REQ-032 Read 0x20 -> rsp_rdata=0x0000DEAD; write 0x04 wstrb=4'b0001 data 0xFFFFFF07 over 3 -> readback 0x07.
REQ-033 Slave holds awready low 5 cycles while wready=1 -> wvalid drops after its handshake, awvalid stays high with stable awaddr, exactly one B accepted.
REQ-034 rsp_ready held low 10 cycles -> rsp_valid and data stable, cmd_ready=0, no new AW/AR issued.
REQ-035 areset pulsed in RD_R -> next cycle all valids/readies 0, state IDLE; misaligned addr 0x06 with macro -> resp 2'b10, no AR.
